// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The sub port exists only when SEQ_CHUNK_ADDER_SUB_EN is defined.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  modport master (output in_valid, x, y, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, x, y, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, x, y, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, x, y, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock with a registered inter-chunk carry.
// Optional subtract mode enabled by defining SEQ_CHUNK_ADDER_SUB_EN.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SH_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SH_W-1:0]  sh_c;
  logic [CHUNK-1:0] x_chunk_c;
  logic [CHUNK-1:0] y_chunk_c;
  logic [CHUNK:0]   add_c;
  logic [WIDTH-1:0] sum_next_c;
  logic             last_c;

  // Current chunk slice, its sum, and the sum register with that slice replaced
  always_comb begin
    sh_c       = SH_W'(idx_q) * SH_W'(CHUNK);
    x_chunk_c  = CHUNK'(x_q >> sh_c);
    y_chunk_c  = CHUNK'(y_q >> sh_c);
    add_c      = {1'b0, x_chunk_c} + {1'b0, y_chunk_c} + (CHUNK+1)'(carry_q);
    sum_next_c = (sum_q & ~(WIDTH'({CHUNK{1'b1}}) << sh_c))
               | (WIDTH'(add_c[CHUNK-1:0]) << sh_c);
    last_c     = (idx_q == IDX_W'(NCHUNK - 1));
  end

  // y_q holds the effective second operand (already inverted for subtract),
  // so the overflow rule below needs no mode awareness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q <= bus.x;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
            if (bus.sub) begin
              y_q     <= ~bus.y;
              carry_q <= 1'b1;
            end else begin
              y_q     <= bus.y;
              carry_q <= bus.cin;
            end
`else
            y_q     <= bus.y;
            carry_q <= bus.cin;
`endif
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ADD;
          end
        end
        ADD: begin
          sum_q   <= sum_next_c;
          carry_q <= add_c[CHUNK];
          idx_q   <= idx_q + IDX_W'(1);
          if (last_c) begin
            cout_q      <= add_c[CHUNK];
            ovf_q       <= (x_q[WIDTH-1] == y_q[WIDTH-1]) &&
                           (add_c[CHUNK-1] != x_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised, multi-cycle successor to the 5-bit ripple adder.
- Adds two WIDTH-bit operands CHUNK bits per clock using a registered carry between chunks.
- Operands enter and results leave through valid/ready handshakes.
- Reports carry out and signed overflow.
- Sits between operand-producing logic and a result consumer, wherever a wide adder would otherwise fail timing or cost too much area.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be ≥2 and an exact multiple of CHUNK.
- CHUNK, 4, bits added per ADD cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set x/y/cin is presented.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  operand X, unsigned or two's complement.
- y  input  WIDTH  operand Y.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout/ovf hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, x + y + cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE; chunk index, carry register, latched operands, sum, cout and ovf all cleared to 0.
  - in_ready = 1 as soon as reset is released; out_valid = 0.
- State machine:
  - IDLE → ADD → DONE → IDLE.
  - in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
- IDLE: on an edge with in_valid=1:
  - latch x, y and cin (cin loaded into the carry register);
  - set index to 0 and go to ADD.
- ADD, once per edge:
  - compute {c, s} = x[idx*CHUNK +: CHUNK] + y[idx*CHUNK +: CHUNK] + carry;
  - write s into sum[idx*CHUNK +: CHUNK] and c into the carry register;
  - increment idx;
  - the edge that processes idx = NCHUNK-1 also sets cout = c and ovf, then goes to DONE.
- ovf definition: ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]), evaluated on the latched operands and final sum.
- Latency:
  - out_valid rises exactly NCHUNK cycles after the accept edge (WIDTH=16, CHUNK=4 → 4 cycles).
  - Minimum accept-to-accept interval is NCHUNK+2 cycles.
- DONE:
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0, for any duration.
  - On an edge with out_ready=1, return to IDLE.
  - No same-cycle re-accept: in_ready stays 0 in DONE.
- Input changes: x, y and cin may change freely after the accept edge without affecting the result in flight.
- in_valid outside IDLE is ignored; no operand is captured or queued.
- Output hold: sum, cout and ovf keep the last result through IDLE. During ADD they update chunk by chunk and are meaningful only while out_valid=1.
- Reset mid-operation: the result in flight is discarded. No out_valid pulse occurs, and all outputs return to reset values.
- Carry chain: a full-width ripple (e.g. 0xFFFF + 1) must propagate through every chunk via the carry register with no extra cycles.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_SUB_EN.
- When defined:
  - adds input port sub (1 bit), latched at the accept edge with the operands;
  - sub=1 computes x - y as x + ~y + 1, with cin ignored and the carry register loaded with 1;
  - cout = 1 means no borrow;
  - ovf uses ~y[WIDTH-1] in place of y[WIDTH-1];
  - sub=0 behaves exactly as the add-only build.
- When undefined: no sub port and add-only behaviour, with identical latency in both builds.

Test Plan (WIDTH=16, CHUNK=4):
- x=0x0001, y=0x0001, cin=0 → sum=0x0002, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- x=0xFFFF, y=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also x=0x7FFF, y=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- x=0x8000, y=0x8000 → sum=0x0000, cout=1, ovf=1. Then x=0x1234, y=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE, and pulse in_valid with new operands meanwhile → out_valid stays 1, sum unchanged, in_ready=0, new operands not captured. Release out_ready → in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously after 2 ADD edges → out_valid=0, sum=0, cout=0, ovf=0 immediately. After release, in_ready=1 and a fresh x=3, y=4 gives sum=0x0007.
- With SEQ_CHUNK_ADDER_SUB_EN defined: x=0x0005, y=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then x=0x8000, y=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
